// File: rtl/avst_adder_arb_pkg.sv
// Shared types and defaults for the round-robin adder arbiter.
package avst_adder_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int DW_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RSP  = 2'd2
  } arb_state_e;

  // Increment with wrap-around at n, used to advance the round-robin pointer.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/avst_adder_arb_rr_pick.sv
// Combinational round-robin selector: first asserted request at or above
// the pointer, wrapping around to index 0.
module avst_adder_arb_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  // Scan from the farthest offset down so the nearest hit above ptr_i wins.
  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_i) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req_i[IW'(j)]) idx_o = IW'(j);
    end
  end

endmodule

// File: rtl/avst_adder_arb.sv
// Round-robin arbiter sharing one streaming adder among N_REQ requesters.
// A grant covers one whole packet: input beats are forwarded to the adder,
// then the adder's result beats are routed back to the same requester.
module avst_adder_arb
  import avst_adder_arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  parameter  int DW    = DW_DEF,
  localparam int GW    = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ-1:0]    req_end,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  output logic [DW-1:0]       rsp_data,
  output logic                rsp_end,
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [DW-1:0]       add_data,
  output logic                add_end,
  output logic                add_valid,
  input  logic                add_ready,
  input  logic [DW-1:0]       res_data,
  input  logic                res_end,
  input  logic                res_valid,
  output logic                res_ready,
  output logic [GW-1:0]       grant_id,
  output logic                busy
);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;

  logic [GW-1:0] pick_idx;
  logic          pick_any;

  logic [DW-1:0] gnt_data;
  logic          gnt_end;
  logic          gnt_valid;
  logic          gnt_rsp_ready;

  avst_adder_arb_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Select the granted requester's input stream and its result-ready bit.
  always_comb begin
    gnt_data      = '0;
    gnt_end       = 1'b0;
    gnt_valid     = 1'b0;
    gnt_rsp_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == GW'(i)) begin
        gnt_data      = req_data[i*DW +: DW];
        gnt_end       = req_end[i];
        gnt_valid     = req_valid[i];
        gnt_rsp_ready = rsp_ready[i];
      end
    end
  end

  // Steer handshakes by state; everything idles at zero outside its phase,
  // which also makes every output zero while reset holds the FSM in IDLE.
  always_comb begin
    req_ready = '0;
    add_data  = '0;
    add_end   = 1'b0;
    add_valid = 1'b0;
    rsp_data  = '0;
    rsp_end   = 1'b0;
    rsp_valid = '0;
    res_ready = 1'b0;
    case (state_q)
      FWD: begin
        add_data             = gnt_data;
        add_end              = gnt_end;
        add_valid            = gnt_valid;
        req_ready[grant_id_q] = add_ready;
      end
      RSP: begin
        rsp_data              = res_data;
        rsp_end               = res_end;
        rsp_valid[grant_id_q] = res_valid;
        res_ready             = gnt_rsp_ready;
      end
      default: ;
    endcase
  end

  // Next-state: grant in IDLE, leave FWD on the last input beat, leave RSP
  // on the last result beat and move the pointer past the served port.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_idx;
          state_d    = FWD;
        end
      end
      FWD: begin
        if (gnt_valid && add_ready && gnt_end) state_d = RSP;
      end
      RSP: begin
        if (res_valid && gnt_rsp_ready && res_end) begin
          state_d  = IDLE;
          rr_ptr_d = GW'(wrap_inc(int'(grant_id_q), N_REQ));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; an asserted reset aborts any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_avst_adder_arb.sv
// Randomized bench for avst_adder_arb with a packet-level reference model
// and an adder model that returns sum-then-zeros result packets.
module tb_avst_adder_arb;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_end, req_valid, req_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_end;
  logic [N-1:0]    rsp_valid, rsp_ready;
  logic [DW-1:0]   add_data;
  logic            add_end, add_valid, add_ready;
  logic [DW-1:0]   res_data;
  logic            res_end, res_valid, res_ready;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  avst_adder_arb #(.N_REQ(N), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req_data(req_data), .req_end(req_end), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_end(rsp_end), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .add_data(add_data), .add_end(add_end), .add_valid(add_valid), .add_ready(add_ready),
    .res_data(res_data), .res_end(res_end), .res_valid(res_valid), .res_ready(res_ready),
    .grant_id(grant_id), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending beats per port, the adder's result queue,
  // expected packet sums, delivered result beats and the grant history.
  logic [8:0] reqq    [N][$];
  logic [8:0] resq    [$];
  logic [7:0] exp_sum [N][$];
  logic [7:0] deliv   [N][$];
  int         glog    [$];
  logic [7:0] psum    [N];
  logic [7:0] acc;
  int  mphase, mgrant, mptr, rsp_cnt;
  bit  rsp_first;

  // Stimulus knobs.
  int  vmode, ar_mode, rr_mode, rv_mode, res_beats;
  bit  stray_en, ar_tog;

  // Handshakes observed on the DUT ports.
  int  dut_hs [N];
  int  dut_add_hs;
  bit  watch_en;
  logic [1:0] watch_idx;
  int  watch_hits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit all_empty();
    bit e;
    e = (resq.size() == 0);
    for (int i = 0; i < N; i++) if (reqq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic push_beat(input logic [1:0] p, input logic [7:0] d, input logic e);
    reqq[p].push_back({e, d});
    psum[p] += d;
    if (e) begin
      exp_sum[p].push_back(psum[p]);
      psum[p] = 8'h00;
    end
  endtask

  task automatic push_rand_pkt(input logic [1:0] p, input int len);
    for (int k = 0; k < len; k++) push_beat(p, 8'($urandom), (k == len - 1));
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      reqq[i].delete(); exp_sum[i].delete(); deliv[i].delete();
      psum[i] = 8'h00; dut_hs[i] = 0;
    end
    resq.delete(); glog.delete();
    acc = 8'h00; mphase = 0; mgrant = 0; mptr = 0; rsp_cnt = 0; rsp_first = 1'b0;
    dut_add_hs = 0; watch_en = 1'b0; watch_hits = 0;
  endtask

  task automatic drive_idle();
    req_valid = '0; req_end = '0; req_data = '0;
    add_ready = 1'b0; rsp_ready = '0;
    res_valid = 1'b0; res_end = 1'b0; res_data = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, "_add_valid"}, 32'(add_valid), 32'(0));
    chk({tag, "_add_end"},   32'(add_end),   32'(0));
    chk({tag, "_rsp_end"},   32'(rsp_end),   32'(0));
    chk({tag, "_res_ready"}, 32'(res_ready), 32'(0));
    chk({tag, "_add_data"},  32'(add_data),  32'(0));
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'(0));
    chk({tag, "_grant_id"},  32'(grant_id),  32'(0));
    chk({tag, "_busy"},      32'(busy),      32'(0));
  endtask

  // Assert reset between clock edges, confirm outputs clear at once,
  // then release on a falling edge with quiet inputs.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs(tag);
    clear_model();
    drive_idle();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One clock: drive inputs, compare outputs against the model, then
  // advance the model by the handshakes that the posedge will complete.
  task automatic step();
    logic [N-1:0] rv, rr;
    logic         ar, resv;
    logic [8:0]   resb;
    logic [7:0]   dd [N];
    logic         de [N];
    logic [N-1:0] e_rq, e_rspv;
    logic         e_av, e_resr;
    logic [1:0]   gi;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      logic [8:0] b;
      b = (reqq[i].size() > 0) ? reqq[i][0] : 9'($urandom);
      rv[i] = (reqq[i].size() > 0) && (vmode == 1 || $urandom_range(0, 3) != 0);
      dd[i] = b[7:0];
      de[i] = b[8];
      req_data[i*DW +: DW] = b[7:0];
      req_end[i] = b[8];
    end
    req_valid = rv;
    ar_tog = ~ar_tog;
    case (ar_mode)
      1:       ar = 1'b1;
      2:       ar = ar_tog;
      3:       ar = 1'b0;
      default: ar = 1'($urandom_range(0, 1));
    endcase
    add_ready = ar;
    if (resq.size() > 0) begin
      resb = resq[0];
      resv = (rv_mode == 1) || ($urandom_range(0, 2) != 0);
    end else begin
      resb = {1'b1, 8'($urandom)};
      resv = stray_en && (mphase == 0) && ($urandom_range(0, 1) == 1);
    end
    res_valid = resv; res_data = resb[7:0]; res_end = resb[8];
    for (int i = 0; i < N; i++) begin
      case (rr_mode)
        1:       rr[i] = 1'b1;
        2:       rr[i] = (rsp_cnt >= 3);
        default: rr[i] = 1'($urandom_range(0, 1));
      endcase
    end
    rsp_ready = rr;
    #1;
    gi = 2'(mgrant);
    e_rq = '0; e_av = 1'b0; e_resr = 1'b0; e_rspv = '0;
    if (mphase == 1) begin e_av = rv[gi]; e_rq[gi] = ar; end
    if (mphase == 2) begin e_rspv[gi] = resv; e_resr = rr[gi]; end
    chk("req_ready", 32'(req_ready), 32'(e_rq));
    chk("add_valid", 32'(add_valid), 32'(e_av));
    chk("res_ready", 32'(res_ready), 32'(e_resr));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rspv));
    chk("grant_id",  32'(grant_id),  32'(mgrant));
    chk("busy",      32'(busy),      32'(mphase != 0));
    if (mphase == 1) begin
      chk("add_data", 32'(add_data), 32'(dd[gi]));
      chk("add_end",  32'(add_end),  32'(de[gi]));
    end
    if (mphase == 2) begin
      chk("rsp_data", 32'(rsp_data), 32'(resb[7:0]));
      chk("rsp_end",  32'(rsp_end),  32'(resb[8]));
    end
    for (int i = 0; i < N; i++) if (rsp_valid[i] && rsp_ready[i]) dut_hs[i]++;
    if (add_valid && add_ready) dut_add_hs++;
    if (watch_en && req_ready[watch_idx]) watch_hits++;
    case (mphase)
      0: begin
        if (|rv) begin
          int p;
          p = -1;
          for (int k = 0; k < N; k++) if (p < 0 && rv[2'(mptr + k)]) p = (mptr + k) % N;
          mgrant = p; mphase = 1; glog.push_back(p);
        end
      end
      1: begin
        if (rv[gi] && ar) begin
          logic [8:0] b;
          b = reqq[gi].pop_front();
          acc += b[7:0];
          if (b[8]) begin
            int nb;
            nb = (res_beats > 0) ? res_beats : int'($urandom_range(1, 4));
            for (int k = 0; k < nb; k++) resq.push_back({(k == nb - 1), (k == 0) ? acc : 8'h00});
            acc = 8'h00; mphase = 2; rsp_cnt = 0; rsp_first = 1'b1;
          end
        end
      end
      default: begin
        if (resv && rr[gi]) begin
          logic [8:0] r;
          r = resq.pop_front();
          deliv[gi].push_back(r[7:0]);
          if (rsp_first) begin
            chk("sum_pending", 32'(exp_sum[gi].size() > 0), 32'(1));
            if (exp_sum[gi].size() > 0) chk("packet_sum", 32'(r[7:0]), 32'(exp_sum[gi].pop_front()));
            rsp_first = 1'b0;
          end
          if (r[8]) begin mphase = 0; mptr = (mgrant + 1) % N; end
        end
        rsp_cnt++;
      end
    endcase
  endtask

  task automatic run_until_done(input string name, input int budget);
    int n;
    n = 0;
    while (!(mphase == 0 && all_empty()) && n < budget) begin step(); n++; end
    chk({name, "_drained"}, 32'(mphase == 0 && all_empty()), 32'(1));
    step();
  endtask

  task automatic set_modes(input int v, input int a, input int r, input int rv, input int nb);
    vmode = v; ar_mode = a; rr_mode = r; rv_mode = rv; res_beats = nb; stray_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int reps;
    clear_model();
    drive_idle();
    ar_tog = 1'b0;
    set_modes(1, 1, 1, 1, 1);
    req_valid = 4'hF; add_ready = 1'b1; res_valid = 1'b1; rsp_ready = 4'hF; res_end = 1'b1;
    #1 reset = 1'b0;
    #2;
    check_reset_outputs("por");
    drive_idle();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single port 1 packet, four result beats.
    set_modes(1, 1, 1, 1, 4);
    push_beat(2'd1, 8'h05, 1'b0);
    push_beat(2'd1, 8'h07, 1'b1);
    run_until_done("p1", 50);
    chk("p1_hs", 32'(dut_hs[1]), 32'(4));
    chk("p1_nbeats", 32'(deliv[1].size()), 32'(4));
    if (deliv[1].size() == 4) begin
      chk("p1_b0", 32'(deliv[1][0]), 32'h0C);
      chk("p1_b1", 32'(deliv[1][1]), 32'h00);
      chk("p1_b3", 32'(deliv[1][3]), 32'h00);
    end
    chk("p1_busy", 32'(busy), 32'(0));
    chk("p1_rr_ptr", 32'(dut.rr_ptr_q), 32'(2));

    // Ports 0 and 2 competing from pointer 0.
    apply_reset("rst_a");
    set_modes(1, 1, 1, 1, 2);
    push_beat(2'd0, 8'h01, 1'b0);
    push_beat(2'd0, 8'h02, 1'b1);
    push_beat(2'd2, 8'h10, 1'b1);
    watch_en = 1'b1; watch_idx = 2'd2;
    reps = 0;
    while (glog.size() < 2 && reps < 40) begin step(); reps++; end
    watch_en = 1'b0;
    chk("p02_port2_held", 32'(watch_hits), 32'(0));
    run_until_done("p02", 50);
    chk("p02_ngrants", 32'(glog.size()), 32'(2));
    if (glog.size() == 2) begin
      chk("p02_g0", 32'(glog[0]), 32'(0));
      chk("p02_g1", 32'(glog[1]), 32'(2));
    end
    chk("p02_sum0", 32'(deliv[0].size() > 0 ? deliv[0][0] : 8'hEE), 32'h03);
    chk("p02_sum2", 32'(deliv[2].size() > 0 ? deliv[2][0] : 8'hEE), 32'h10);

    // All four ports continuously requesting.
    apply_reset("rst_b");
    set_modes(1, 1, 1, 1, 1);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) push_rand_pkt(2'(p), int'($urandom_range(1, 3)));
    run_until_done("rr4", 200);
    chk("rr4_ngrants", 32'(glog.size()), 32'(8));
    if (glog.size() >= 5) begin
      chk("rr4_g0", 32'(glog[0]), 32'(0));
      chk("rr4_g1", 32'(glog[1]), 32'(1));
      chk("rr4_g2", 32'(glog[2]), 32'(2));
      chk("rr4_g3", 32'(glog[3]), 32'(3));
      chk("rr4_g4", 32'(glog[4]), 32'(0));
    end
    reps = 0;
    for (int k = 1; k < glog.size(); k++) if (glog[k] == glog[k-1]) reps++;
    chk("rr4_no_repeat", 32'(reps), 32'(0));

    // Toggling add_ready and rsp_ready held low at the start of each result.
    apply_reset("rst_c");
    set_modes(1, 2, 2, 1, 3);
    push_beat(2'd2, 8'h10, 1'b0);
    push_beat(2'd2, 8'h20, 1'b0);
    push_beat(2'd2, 8'h30, 1'b1);
    push_beat(2'd1, 8'hF0, 1'b0);
    push_beat(2'd1, 8'h20, 1'b1);
    run_until_done("stall", 200);
    chk("stall_add_hs", 32'(dut_add_hs), 32'(5));
    chk("stall_hs1", 32'(dut_hs[1]), 32'(3));
    chk("stall_hs2", 32'(dut_hs[2]), 32'(3));
    chk("stall_sum1", 32'(deliv[1].size() > 0 ? deliv[1][0] : 8'hEE), 32'h10);
    chk("stall_sum2", 32'(deliv[2].size() > 0 ? deliv[2][0] : 8'hEE), 32'h60);

    // Single-beat packet on port 0.
    apply_reset("rst_d");
    set_modes(1, 1, 1, 1, 2);
    push_beat(2'd0, 8'hFF, 1'b1);
    run_until_done("one", 50);
    chk("one_add_hs", 32'(dut_add_hs), 32'(1));
    chk("one_hs0", 32'(dut_hs[0]), 32'(2));
    chk("one_hs_other", 32'(dut_hs[1] + dut_hs[2] + dut_hs[3]), 32'(0));
    chk("one_sum", 32'(deliv[0].size() > 0 ? deliv[0][0] : 8'hEE), 32'hFF);

    // Reset in the middle of a port 3 packet.
    apply_reset("rst_e");
    set_modes(1, 3, 1, 1, 1);
    push_rand_pkt(2'd3, 4);
    reps = 0;
    while (mphase != 1 && reps < 10) begin step(); reps++; end
    step();
    step();
    chk("midfwd_busy", 32'(busy), 32'(1));
    apply_reset("rst_mid");
    chk("post_rst_ptr", 32'(dut.rr_ptr_q), 32'(0));
    set_modes(1, 1, 1, 1, 1);
    push_beat(2'd3, 8'h11, 1'b0);
    push_beat(2'd3, 8'h22, 1'b1);
    run_until_done("p3", 50);
    chk("p3_grant", 32'(glog.size() > 0 ? glog[0] : -1), 32'(3));
    chk("p3_grant_id", 32'(grant_id), 32'(3));
    chk("p3_sum", 32'(deliv[3].size() > 0 ? deliv[3][0] : 8'hEE), 32'h33);
    chk("p3_ptr_wrap", 32'(dut.rr_ptr_q), 32'(0));

    // Randomized traffic with random stalls and stray adder results in IDLE.
    for (int r = 0; r < 3; r++) begin
      apply_reset("rst_rand");
      set_modes(r == 0 ? 1 : 0, r, 0, 0, 0);
      stray_en = 1'b1;
      for (int k = 0; k < 30; k++) push_rand_pkt(2'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
      run_until_done("rand", 4000);
      reps = 0;
      for (int p = 0; p < N; p++) reps += exp_sum[p].size();
      chk("rand_all_sums_returned", 32'(reps), 32'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
